// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row synchronizer, scan-level debounce,
// and conversion of accepted presses into key/time_button/alarm_button stimulus.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int HOLD_CYCLES    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_drive_n,
  output logic [3:0] key,
  output logic       time_button,
  output logic       alarm_button,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_ACCEPT   = 3'd2,
    S_EMIT     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  localparam int             DW        = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [15:0]    DEB_N     = 16'(DEBOUNCE_SCANS);
  localparam logic [15:0]    HOLD_N    = 16'(HOLD_CYCLES);
  localparam logic [3:0]     KEY_NONE  = 4'd10;
  localparam logic [3:0]     CODE_STAR = 4'd10;
  localparam logic [3:0]     CODE_HASH = 4'd11;

  state_t        state;
  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col;
  logic [3:0]    hit_c0, hit_c1;
  logic [11:0]   hits;
  logic [3:0]    scan_code;
  logic [3:0]    cand;
  logic [15:0]   deb_cnt;
  logic [15:0]   hold_cnt;
  logic          scan_tick, scan_done, single;

  assign state_dbg = state;

  // Internal codes: digits 0-9, '*' = 10, '#' = 11; only 0-9 ever reach key.
  function automatic logic [3:0] key_code(input int idx);
    case (idx)
      0: key_code = 4'd1;   1: key_code = 4'd2;   2: key_code = 4'd3;
      3: key_code = 4'd4;   4: key_code = 4'd5;   5: key_code = 4'd6;
      6: key_code = 4'd7;   7: key_code = 4'd8;   8: key_code = 4'd9;
      9: key_code = CODE_STAR; 10: key_code = 4'd0; 11: key_code = CODE_HASH;
      default: key_code = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  assign scan_tick = (div_cnt == DIV_LAST);
  assign scan_done = scan_tick && (col == 2'd2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      col         <= 2'd0;
      col_drive_n <= 3'b110;
      hit_c0      <= 4'd0;
      hit_c1      <= 4'd0;
    end else if (scan_tick) begin
      div_cnt <= '0;
      case (col)
        2'd0: begin hit_c0 <= ~row_s2; col <= 2'd1; col_drive_n <= 3'b101; end
        2'd1: begin hit_c1 <= ~row_s2; col <= 2'd2; col_drive_n <= 3'b011; end
        default: begin col <= 2'd0; col_drive_n <= 3'b110; end
      endcase
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Column 2 is taken straight from the synchronizer on the scan-complete edge.
  always_comb begin
    hits = '0;
    for (int r = 0; r < 4; r++) begin
      hits[r*3]     = hit_c0[r];
      hits[r*3 + 1] = hit_c1[r];
      hits[r*3 + 2] = ~row_s2[r];
    end
  end

  assign single = (hits != 12'd0) && ((hits & (hits - 12'd1)) == 12'd0);

  always_comb begin
    scan_code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (hits[i]) scan_code = key_code(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cand         <= 4'd0;
      deb_cnt      <= 16'd0;
      hold_cnt     <= 16'd0;
      key          <= KEY_NONE;
      time_button  <= 1'b0;
      alarm_button <= 1'b0;
    end else begin
      time_button  <= 1'b0;
      alarm_button <= 1'b0;
      case (state)
        S_IDLE: begin
          if (scan_done && single) begin
            cand    <= scan_code;
            deb_cnt <= 16'd1;
            if (DEB_N == 16'd1) begin
              state        <= S_ACCEPT;
              time_button  <= (scan_code == CODE_STAR);
              alarm_button <= (scan_code == CODE_HASH);
            end else begin
              state <= S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (scan_done) begin
            if (single && scan_code == cand) begin
              deb_cnt <= deb_cnt + 16'd1;
              if (deb_cnt + 16'd1 == DEB_N) begin
                state        <= S_ACCEPT;
                time_button  <= (cand == CODE_STAR);
                alarm_button <= (cand == CODE_HASH);
              end
            end else begin
              state   <= S_IDLE;
              deb_cnt <= 16'd0;
            end
          end
        end
        S_ACCEPT: begin
          deb_cnt <= 16'd0;
          if (cand < 4'd10) begin
            state    <= S_EMIT;
            key      <= cand;
            hold_cnt <= 16'd1;
          end else begin
            state <= S_RELEASE;
          end
        end
        S_EMIT: begin
          if (hold_cnt == HOLD_N) begin
            key   <= KEY_NONE;
            state <= S_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        S_RELEASE: begin
          // A held key keeps restarting the quiet count, so there is no auto-repeat.
          if (scan_done) begin
            if (single) begin
              deb_cnt <= 16'd0;
            end else if (deb_cnt + 16'd1 == DEB_N) begin
              deb_cnt <= 16'd0;
              state   <= S_IDLE;
            end else begin
              deb_cnt <= deb_cnt + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad short model, time-indexed reference model of
// scan/debounce/emit behaviour, table-driven presses, corner sequences, random presses.
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int DEB  = 2;
  localparam int HOLD = 3;
  localparam int SCAN = 3 * SD;
  localparam int MAXE = 8192;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic [2:0]  col_drive_n;
  logic [3:0]  key;
  logic        time_button, alarm_button;
  logic [2:0]  state_dbg;
  logic [11:0] pressed = 12'd0;

  always #5 clock = ~clock;

  // Pressed switch (r,c) pulls row r low while column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r*3 +: 3] & ~col_drive_n);
  end

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .row_n(row_n), .col_drive_n(col_drive_n),
    .key(key), .time_button(time_button), .alarm_button(alarm_button),
    .state_dbg(state_dbg)
  );

  typedef struct {
    int code;
    int hold_clk;
    int exp_cycles;
    int exp_digit;
    int exp_tb;
    int exp_ab;
    int exp_first;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int keymap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  int          n_edge;
  logic [11:0] hist    [MAXE];
  int          exp_key [MAXE];
  int          exp_tb  [MAXE];
  int          exp_ab  [MAXE];
  int          m_cand, m_streak, m_locked, m_quiet, m_busy;
  int          obs_key_cycles, obs_tb, obs_ab, obs_first, obs_digit;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, n_edge, act, exp);
    end
  endfunction

  function automatic logic [11:0] kb(int code);
    logic [11:0] v = 12'd0;
    for (int i = 0; i < 12; i++) if (keymap[i] == code) v[i] = 1'b1;
    return v;
  endfunction

  function automatic void model_reset();
    n_edge = 0;
    for (int i = 0; i < MAXE; i++) begin
      exp_key[i] = 10; exp_tb[i] = 0; exp_ab[i] = 0;
    end
    m_cand = -1; m_streak = 0; m_locked = 0; m_quiet = 0; m_busy = 0;
    obs_key_cycles = 0; obs_tb = 0; obs_ab = 0; obs_first = -1; obs_digit = -1;
  endfunction

  // Column c of the scan ending at edge n saw the keypad as it stood 2 edges
  // before its sample edge, which lies (2-c)*SD edges before n.
  function automatic int scan_result(int n);
    int cnt = 0;
    int code = -1;
    for (int c = 0; c < 3; c++) begin
      int idx = n - (2 - c) * SD - 2;
      for (int r = 0; r < 4; r++) begin
        if (hist[idx][r*3 + c]) begin
          cnt++;
          code = keymap[r*3 + c];
        end
      end
    end
    return (cnt == 1) ? code : -1;
  endfunction

  function automatic void model_scan(int n, int res);
    if (!m_locked) begin
      if (res >= 0 && (m_streak == 0 || res == m_cand)) begin
        if (m_streak == 0) m_cand = res;
        m_streak++;
      end else begin
        m_streak = 0;
      end
      if (m_streak == DEB) begin
        if (m_cand < 10) begin
          for (int i = 1; i <= HOLD; i++) exp_key[n + i] = m_cand;
          m_busy = n + 1 + HOLD;
        end else begin
          if (m_cand == 10) exp_tb[n] = 1;
          else exp_ab[n] = 1;
          m_busy = n + 1;
        end
        m_locked = 1; m_quiet = 0; m_streak = 0;
      end
    end else if (n > m_busy) begin
      if (res >= 0) m_quiet = 0;
      else m_quiet++;
      if (m_quiet == DEB) m_locked = 0;
    end
  endfunction

  function automatic void sample_cycle();
    if (!reset) begin
      model_reset();
      chk("rst_key", int'(key), 10);
      chk("rst_time_button", int'(time_button), 0);
      chk("rst_alarm_button", int'(alarm_button), 0);
      chk("rst_col_drive_n", int'(col_drive_n), 6);
    end else begin
      int c;
      n_edge++;
      if (n_edge >= MAXE - HOLD - 4) begin
        $display("FAIL edge_budget edge=%0d got=%0d expected_below=%0d", n_edge, n_edge, MAXE - HOLD - 4);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
      end
      hist[n_edge] = pressed;
      if (n_edge % SCAN == 0) model_scan(n_edge, scan_result(n_edge));
      c = (n_edge / SD) % 3;
      chk("key", int'(key), exp_key[n_edge]);
      chk("time_button", int'(time_button), exp_tb[n_edge]);
      chk("alarm_button", int'(alarm_button), exp_ab[n_edge]);
      chk("col_drive_n", int'(col_drive_n), (c == 0) ? 6 : (c == 1) ? 5 : 3);
      if (key != 4'd10) begin
        obs_key_cycles++;
        obs_digit = int'(key);
        if (obs_first < 0) obs_first = n_edge;
      end
      obs_tb += int'(time_button);
      obs_ab += int'(alarm_button);
    end
  endfunction

  task automatic tick();
    @(negedge clock);
    sample_cycle();
  endtask

  task automatic do_reset(int cyc);
    reset = 1'b0;
    repeat (cyc) tick();
    #1 reset = 1'b1;
  endtask

  task automatic hold(logic [11:0] p, int cyc);
    pressed = p;
    repeat (cyc) tick();
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1, 200, 3, 1, 0, 0, 25};
    vecs[1] = '{9, 200, 3, 9, 0, 0, 25};
    vecs[2] = '{0, 200, 3, 0, 0, 0, 25};
    vecs[3] = '{5, 200, 3, 5, 0, 0, 25};
    vecs[4] = '{10, 200, 0, 0, 1, 0, -1};
    vecs[5] = '{11, 200, 0, 0, 0, 1, -1};
    vecs[6] = '{5, 12, 0, 0, 0, 0, -1};
    vecs[7] = '{8, 30, 3, 8, 0, 0, 25};
    vecs[8] = '{3, 14, 0, 0, 0, 0, -1};
    vecs[9] = '{7, 120, 3, 7, 0, 0, 25};

    // Reset held with a key pressed, then free-running column scan.
    pressed = kb(5);
    do_reset(5);
    hold(kb(5), 40);
    hold(12'd0, 40);

    for (int i = 0; i < 10; i++) begin
      do_reset(3);
      hold(kb(vecs[i].code), vecs[i].hold_clk);
      hold(12'd0, 60);
      chk("tbl_key_cycles", obs_key_cycles, vecs[i].exp_cycles);
      chk("tbl_time_pulses", obs_tb, vecs[i].exp_tb);
      chk("tbl_alarm_pulses", obs_ab, vecs[i].exp_ab);
      if (vecs[i].exp_cycles > 0) begin
        chk("tbl_digit", obs_digit, vecs[i].exp_digit);
        chk("tbl_first_edge", obs_first, vecs[i].exp_first);
      end
    end

    // 5 and 6 alternating scan by scan never qualify.
    do_reset(3);
    for (int i = 0; i < 6; i++) begin
      hold(kb(5), SCAN);
      hold(kb(6), SCAN);
    end
    hold(12'd0, 40);
    chk("alt_key_cycles", obs_key_cycles, 0);
    chk("alt_buttons", obs_tb + obs_ab, 0);

    // Two keys together are ignored; the survivor is then accepted.
    do_reset(3);
    hold(kb(1) | kb(2), 10 * SCAN);
    chk("multi_key_cycles", obs_key_cycles, 0);
    hold(kb(1), 60);
    hold(12'd0, 60);
    chk("multi_then_1_cycles", obs_key_cycles, 3);
    chk("multi_then_1_digit", obs_digit, 1);

    // Reset dropped in the second EMIT clock of digit 7.
    do_reset(3);
    hold(kb(7), 26);
    chk("pre_reset_key", int'(key), 7);
    reset = 1'b0;
    #1;
    chk("async_reset_key", int'(key), 10);
    chk("async_reset_col", int'(col_drive_n), 6);
    repeat (3) tick();
    #1 reset = 1'b1;
    hold(kb(7), 60);
    hold(12'd0, 60);
    chk("reaccept_7_cycles", obs_key_cycles, 3);
    chk("reaccept_7_digit", obs_digit, 7);
    chk("reaccept_7_first", obs_first, 25);

    // Random presses, single and double, checked cycle by cycle by the model.
    do_reset(3);
    for (int i = 0; i < 25; i++) begin
      int kind = $urandom_range(0, 9);
      logic [11:0] p;
      if (kind <= 6) p = kb(keymap[$urandom_range(0, 11)]);
      else if (kind <= 8) p = kb(keymap[$urandom_range(0, 11)]) | kb(keymap[$urandom_range(0, 11)]);
      else p = 12'd0;
      hold(p, $urandom_range(4, 90));
    end
    hold(12'd0, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
